// File: rtl/conv1x1_multich_engine.sv
// Multi-channel 1x1 convolution engine: per-pixel MAC of IN_CH unsigned activations against
// OUT_CH signed weight columns, followed by bias, rounding shift, optional ReLU and saturation.
module conv1x1_requant #(
    parameter int ACC_WIDTH  = 24,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  logic [ACC_WIDTH-1:0]  sum,
    input  logic [BIAS_WIDTH-1:0] bias,
    input  logic [4:0]            shift,
    input  logic                  relu_en,
    output logic [OUT_WIDTH-1:0]  res,
    output logic                  sat
);
    // Two guard bits keep bias add plus rounding constant free of wrap-around.
    localparam int TW = ACC_WIDTH + 2;
    localparam logic signed [TW-1:0] MAXV = {{(TW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [TW-1:0] MINV = ~MAXV;

    logic signed [TW-1:0] t0, t1, r0, r1;

    always_comb begin
        t0 = $signed({{(TW-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum})
           + $signed({{(TW-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias});
        t1 = t0;
        if (shift != 5'd0) t1 = t0 + $signed(TW'(1) << (shift - 5'd1));
        r0 = t1 >>> shift;
        if (relu_en && r0 < 0) r0 = '0;
        r1  = r0;
        sat = 1'b0;
        if (r0 > MAXV) begin
            r1  = MAXV;
            sat = 1'b1;
        end else if (r0 < MINV) begin
            r1  = MINV;
            sat = 1'b1;
        end
        res = r1[OUT_WIDTH-1:0];
    end
endmodule

module conv1x1_multich_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int IN_CH      = 16,
    parameter int OUT_CH     = 4,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [OUT_CH*OUT_WIDTH-1:0]   dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [OUT_CH-1:0]             sat_flag,
    input  logic                          cfg_we,
    input  logic                          cfg_bias_we,
    input  logic [$clog2(OUT_CH)-1:0]     cfg_lane,
    input  logic [$clog2(IN_CH)-1:0]      cfg_ch,
    input  logic [WGT_WIDTH-1:0]          cfg_wgt,
    input  logic [BIAS_WIDTH-1:0]         cfg_bias,
    input  logic [4:0]                    cfg_shift,
    input  logic                          relu_en
);
    localparam int CW = $clog2(IN_CH);
    localparam int PW = DATA_WIDTH + WGT_WIDTH + 1;

    logic [WGT_WIDTH-1:0]  w_q [OUT_CH][IN_CH];
    logic [WGT_WIDTH-1:0]  w_d [OUT_CH][IN_CH];
    logic [BIAS_WIDTH-1:0] b_q [OUT_CH];
    logic [BIAS_WIDTH-1:0] b_d [OUT_CH];
    logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
    logic [OUT_CH-1:0][PW-1:0]        prod_q, prod_d;
    logic [OUT_CH-1:0][ACC_WIDTH-1:0] acc_q, acc_d, sum;
    logic [OUT_CH-1:0][OUT_WIDTH-1:0] dout_q, dout_d, rq_res;
    logic [OUT_CH-1:0]     sat_q, sat_d, rq_sat;
    logic v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
    logic dout_valid_q, dout_valid_d;
    logic pipe_en, accept;

    for (genvar k = 0; k < OUT_CH; k++) begin : g_lane
        assign sum[k] = (first1_q ? '0 : acc_q[k])
                      + {{(ACC_WIDTH-PW){prod_q[k][PW-1]}}, prod_q[k]};
        conv1x1_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .BIAS_WIDTH(BIAS_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_rq (
            .sum    (sum[k]),
            .bias   (b_q[k]),
            .shift  (cfg_shift),
            .relu_en(relu_en),
            .res    (rq_res[k]),
            .sat    (rq_sat[k])
        );
    end

    always_comb begin
        pipe_en   = !dout_valid_q || dout_ready;
        din_ready = pipe_en && !cfg_we && !cfg_bias_we && !clr;
        accept    = din_valid && din_ready;

        w_d = w_q;
        b_d = b_q;
        if (cfg_we && 32'(cfg_lane) < OUT_CH && 32'(cfg_ch) < IN_CH)
            w_d[cfg_lane][cfg_ch] = cfg_wgt;
        if (cfg_bias_we && 32'(cfg_lane) < OUT_CH)
            b_d[cfg_lane] = cfg_bias;

        ch_cnt_d     = ch_cnt_q;
        prod_d       = prod_q;
        v1_d         = v1_q;
        first1_d     = first1_q;
        last1_d      = last1_q;
        acc_d        = acc_q;
        dout_d       = dout_q;
        sat_d        = sat_q;
        dout_valid_d = dout_valid_q;

        if (accept)
            ch_cnt_d = (ch_cnt_q == CW'(IN_CH-1)) ? '0 : ch_cnt_q + CW'(1);

        if (pipe_en) begin
            for (int k = 0; k < OUT_CH; k++)
                prod_d[k] = $signed({1'b0, din}) * $signed(w_q[k][ch_cnt_q]);
            v1_d         = accept;
            first1_d     = (ch_cnt_q == '0);
            last1_d      = (ch_cnt_q == CW'(IN_CH-1));
            dout_valid_d = 1'b0;
            if (v1_q) begin
                if (last1_q) begin
                    acc_d        = '0;
                    dout_d       = rq_res;
                    sat_d        = rq_sat;
                    dout_valid_d = 1'b1;
                end else begin
                    acc_d = sum;
                end
            end
        end

        // Soft clear drops in-flight work but leaves weights/biases intact.
        if (clr) begin
            ch_cnt_d     = '0;
            v1_d         = 1'b0;
            acc_d        = '0;
            dout_valid_d = 1'b0;
            sat_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < OUT_CH; k++) begin
                b_q[k] <= '0;
                for (int c = 0; c < IN_CH; c++) w_q[k][c] <= '0;
            end
            ch_cnt_q     <= '0;
            prod_q       <= '0;
            v1_q         <= 1'b0;
            first1_q     <= 1'b0;
            last1_q      <= 1'b0;
            acc_q        <= '0;
            dout_q       <= '0;
            sat_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            w_q          <= w_d;
            b_q          <= b_d;
            ch_cnt_q     <= ch_cnt_d;
            prod_q       <= prod_d;
            v1_q         <= v1_d;
            first1_q     <= first1_d;
            last1_q      <= last1_d;
            acc_q        <= acc_d;
            dout_q       <= dout_d;
            sat_q        <= sat_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sat_flag   = sat_q;
endmodule
